// File: rtl/exp4_unidade_controle.sv
// Control unit for the memory game: a Moore FSM whose outputs are registered together with the state.
// Optional play timeout is enabled with the EXP4_TIMEOUT_EN macro.
module exp4_unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       igual,
    input  logic       fimC,
    input  logic       jogada_feita,
    input  logic       controle_timeout,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARACAO    = 4'h1,
        ESPERA_JOGADA = 4'h3,  // datapath counts the timeout only in this code
        REGISTRA      = 4'h4,
        COMPARACAO    = 4'h5,
        PROXIMO       = 4'h6,
        FIM_ACERTOU   = 4'hA,
        FIM_TIMEOUT   = 4'hD,
        FIM_ERROU     = 4'hE
    } state_t;

    state_t state_reg;
    state_t state_next;

`ifndef EXP4_TIMEOUT_EN
    logic unused_timeout_in;
    assign unused_timeout_in = controle_timeout;
`endif

    // Output word order: {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
    function automatic logic [7:0] decode_outputs(input state_t s);
        logic [7:0] o;
        o = 8'b0000_0000;
        case (s)
            PREPARACAO:  o = 8'b1010_0000;
            REGISTRA:    o = 8'b0001_0000;
            PROXIMO:     o = 8'b0100_0000;
            FIM_ACERTOU: o = 8'b0000_1100;
            FIM_ERROU:   o = 8'b0000_1010;
`ifdef EXP4_TIMEOUT_EN
            FIM_TIMEOUT: o = 8'b0000_1001;
`endif
            default:     o = 8'b0000_0000;
        endcase
        return o;
    endfunction

    always_comb begin
        state_next = INICIAL;
        case (state_reg)
            INICIAL:       state_next = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:    state_next = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (jogada_feita)
                    state_next = REGISTRA;
`ifdef EXP4_TIMEOUT_EN
                else if (controle_timeout)
                    state_next = FIM_TIMEOUT;
`endif
                else
                    state_next = ESPERA_JOGADA;
            end
            REGISTRA:      state_next = COMPARACAO;
            COMPARACAO: begin
                if (!igual)
                    state_next = FIM_ERROU;
                else if (fimC)
                    state_next = FIM_ACERTOU;
                else
                    state_next = PROXIMO;
            end
            PROXIMO:       state_next = ESPERA_JOGADA;
            FIM_ACERTOU:   state_next = iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:     state_next = iniciar ? PREPARACAO : FIM_ERROU;
`ifdef EXP4_TIMEOUT_EN
            FIM_TIMEOUT:   state_next = iniciar ? PREPARACAO : FIM_TIMEOUT;
`endif
            default:       state_next = INICIAL;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= INICIAL;
            {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout} <= 8'b0000_0000;
        end else begin
            state_reg <= state_next;
            {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout} <= decode_outputs(state_next);
        end
    end

    assign db_estado = state_reg;

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Directed bench for exp4_unidade_controle: expected state/outputs are queued at drive time
// and compared one clock later; also honours EXP4_TIMEOUT_EN.
module tb_exp4_unidade_controle;

    logic       clock = 1'b0;
    logic       reset, iniciar, igual, fimC, jogada_feita, controle_timeout;
    logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    int n_assert = 0;
    int n_fail   = 0;
    int conta_cnt = 0;

    logic [11:0] exp_q[$];
    string       tag_q[$];

    always #10 clock = ~clock;

    exp4_unidade_controle dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .igual(igual), .fimC(fimC),
        .jogada_feita(jogada_feita), .controle_timeout(controle_timeout),
        .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
        .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
        .db_estado(db_estado)
    );

    // {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout} expected in each state
    function automatic logic [7:0] outs_for(input logic [3:0] st);
        case (st)
            4'h1:    return 8'b1010_0000;
            4'h4:    return 8'b0001_0000;
            4'h6:    return 8'b0100_0000;
            4'hA:    return 8'b0000_1100;
            4'hE:    return 8'b0000_1010;
            4'hD:    return 8'b0000_1001;
            default: return 8'b0000_0000;
        endcase
    endfunction

    task automatic step(input logic rst, input logic ini, input logic jf, input logic ig,
                        input logic fc, input logic to, input logic [3:0] exp_st, input string tag);
        logic [11:0] got, e;
        string t;
        @(negedge clock);
        reset = rst; iniciar = ini; jogada_feita = jf; igual = ig; fimC = fc; controle_timeout = to;
        exp_q.push_back({exp_st, outs_for(exp_st)});
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        got = {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_assert++;
        assert (got === e) else begin
            n_fail++;
            $error("FAIL %s: observed state/outs %h, expected %h", t, got, e);
        end
        if (contaC === 1'b1) conta_cnt++;
    endtask

    // One play: pulse, registra, comparacao, then the decision state (and back to espera if proximo)
    task automatic play(input logic ig, input logic fc, input logic [3:0] result, input string tag);
        step(0, 0, 1, ig, fc, 0, 4'h4, {tag, "_registra"});
        step(0, 0, 0, ig, fc, 0, 4'h5, {tag, "_comparacao"});
        step(0, 0, 0, ig, fc, 0, result, {tag, "_result"});
        if (result == 4'h6)
            step(0, 0, 0, ig, fc, 0, 4'h3, {tag, "_espera"});
    endtask

    initial begin
        reset = 1; iniciar = 0; igual = 0; fimC = 0; jogada_feita = 0; controle_timeout = 0;

        step(1, 0, 0, 0, 0, 0, 4'h0, "reset_state");
        step(1, 1, 1, 1, 1, 1, 4'h0, "reset_priority");
        step(0, 0, 0, 0, 0, 0, 4'h0, "idle_inicial");
        step(0, 1, 0, 0, 0, 0, 4'h1, "start_preparacao");
        step(0, 0, 0, 0, 0, 0, 4'h3, "start_espera");
        step(0, 1, 0, 0, 0, 0, 4'h3, "iniciar_ignored_espera");

        // Full match: 16 plays, fimC only on the last
        conta_cnt = 0;
        for (int i = 0; i < 15; i++)
            play(1, 0, 4'h6, $sformatf("match%0d", i));
        play(1, 1, 4'hA, "match15");
        step(0, 0, 0, 0, 0, 0, 4'hA, "acertou_hold");
        n_assert++;
        assert (conta_cnt == 15) else begin
            n_fail++;
            $error("FAIL contaC_pulses: observed %0d, expected 15", conta_cnt);
        end

        step(0, 1, 0, 0, 0, 0, 4'h1, "restart_from_acertou");
        step(0, 0, 0, 0, 0, 0, 4'h3, "restart_espera");

        // Mismatch on third play
        play(1, 0, 4'h6, "mis0");
        play(1, 0, 4'h6, "mis1");
        step(0, 0, 0, 0, 0, 0, 4'h3, "wait_no_pulse");
        play(0, 0, 4'hE, "mis2");
        step(0, 0, 0, 1, 1, 0, 4'hE, "errou_hold");
        step(0, 1, 0, 0, 0, 0, 4'h1, "restart_from_errou");
        step(0, 0, 0, 0, 0, 0, 4'h3, "restart_espera2");

        // Priority of jogada_feita over controle_timeout
        step(0, 0, 1, 1, 0, 1, 4'h4, "priority_registra");
        step(0, 0, 0, 1, 0, 0, 4'h5, "priority_comparacao");
        step(0, 0, 0, 1, 0, 0, 4'h6, "priority_proximo");
        step(0, 0, 0, 1, 0, 0, 4'h3, "priority_espera");

`ifdef EXP4_TIMEOUT_EN
        step(0, 0, 0, 0, 0, 1, 4'hD, "timeout_enter");
        step(0, 0, 0, 0, 0, 0, 4'hD, "timeout_hold");
        step(0, 1, 0, 0, 0, 0, 4'h1, "restart_from_timeout");
        step(0, 0, 0, 0, 0, 0, 4'h3, "restart_espera3");
`else
        step(0, 0, 0, 0, 0, 1, 4'h3, "timeout_ignored");
        step(0, 0, 0, 0, 0, 1, 4'h3, "timeout_ignored2");
`endif

        // Reset mid-game from comparacao
        step(0, 0, 1, 1, 0, 0, 4'h4, "mid_registra");
        step(0, 0, 0, 1, 0, 0, 4'h5, "mid_comparacao");
        step(1, 0, 0, 1, 0, 0, 4'h0, "reset_from_comparacao");
        step(0, 0, 0, 0, 0, 0, 4'h0, "after_reset_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
